uart_sdram_cmd_bridge: RTL
==========================

// Module: uart_sdram_cmd_bridge
// PURPOSE
//  Byte-stream command interpreter between the UART core and sdram_ctrl; the successor to the single-byte board test FSM.
//  Full-width multi-byte addresses and data, burst reads, write acknowledges, error codes and an inter-byte timeout.
//  Sits in the FPGA top level: UART rx/tx byte handshakes on one side, sdram_ctrl request ports on the other.
// PARAMETERS
//  AddrWidth      22           SDRAM word address width
//  DataWidth      16           SDRAM word width
//  TimeoutCycles  1_000_000    idle clocks allowed between bytes of one command
//  MaxBurst       256          maximum burst words; count byte N gives N+1 words, so MaxBurst <= 256
// PORTS
//  i_clk        in   1          system clock (SDRAM controller clock)
//  i_rst        in   1          synchronous reset, active-high
//  i_rx_data    in   8          received UART byte
//  i_rx_rdy     in   1          rx byte available
//  o_rx_req     out  1          1-cycle pulse: rx byte consumed
//  o_tx_data    out  8          byte to transmit
//  o_tx_req     out  1          1-cycle pulse: transmit o_tx_data
//  i_tx_rdy     in   1          UART transmitter idle
//  o_wr_req     out  1          1-cycle write request
//  o_wr_addr    out  AddrWidth  write address
//  o_wr_data    out  DataWidth  write data
//  o_rd_req     out  1          1-cycle read request
//  o_rd_addr    out  AddrWidth  read address
//  i_rd_data    in   DataWidth  read data
//  i_rd_rdy     in   1          i_rd_data valid, 1 cycle
//  i_ctrl_rdy   in   1          controller accepts a request this cycle
// BEHAVIOUR
//  Reset: state IDLE; every output 0; byte counters and timeout counter 0.
//  AB = ceil(AddrWidth/8), DB = ceil(DataWidth/8). Multi-byte fields are MSB first; excess high bits are dropped.
//  Rx consume: when i_rx_rdy and o_rx_req was low last cycle, latch the byte and pulse o_rx_req. Never two pulses back to back.
//  Commands:
//   'w'(0x77) + AB addr + DB data -> write, then tx 'K'(0x4B).
//   'r'(0x72) + AB addr           -> read, then tx DB data bytes.
//   'b'(0x62) + AB addr + count N -> N+1 reads at addr, addr+1, ...; each word sent as DB bytes.
//  States: IDLE, GET_ADDR, GET_DATA, GET_COUNT, ISSUE_WR, ISSUE_RD, WAIT_RD, SEND, SEND_ACK, SEND_ERR.
//   IDLE: a byte moves to GET_ADDR if it is a valid opcode; otherwise go to SEND_ERR with code '?'(0x3F).
//   GET_ADDR -> GET_DATA ('w'), GET_COUNT ('b') or ISSUE_RD ('r') after AB bytes.
//   ISSUE_*: hold until i_ctrl_rdy, then pulse the request one cycle with address/data stable from the same edge.
//   WAIT_RD: capture i_rd_data on i_rd_rdy, then SEND. SEND: one byte per i_tx_rdy, pulse o_tx_req. o_tx_data is valid in the o_tx_req cycle.
//   After the last byte: if burst words remain, increment the address and go to ISSUE_RD; otherwise go to IDLE.
//  Address increments modulo 2^AddrWidth; a burst wraps from max to 0 silently.
//  Timeout: in GET_* states, count cycles without a consumed byte. At TimeoutCycles, abort the partial command, go to SEND_ERR with '!'(0x21), then IDLE.
//  The timeout counter is cleared on every consumed byte and is inactive in other states.
//  Bytes received while in ISSUE/WAIT/SEND states stay unconsumed: o_rx_req stays low and the UART buffers them.
//  i_rd_rdy outside WAIT_RD is ignored. A request is never reissued while waiting on a read.
//  Reset mid-command or mid-burst: immediately back to IDLE, all outputs 0, no partial tx. Any pending SDRAM op completes unobserved.
// STRUCTURE
//  Package uart_sdram_bridge_pkg: state enum bridge_state_t; opcode constants CMD_WR/CMD_RD/CMD_BURST; response bytes RSP_ACK/RSP_BADCMD/RSP_TIMEOUT.
//  Sub-module bridge_timeout_ctr (load/clear/expire, TimeoutCycles param); all else in one FSM with datapath.
// TESTING
//  1. Send 77 3F FF FF 12 34 -> one o_wr_req, addr 0x3FFFFF, data 0x1234; tx 0x4B.
//  2. Send 72 00 00 05 with i_rd_data=0xBEEF -> one o_rd_req at addr 5; tx BE then EF.
//  3. Send 62 3F FF FE 02 -> reads at 0x3FFFFE, 0x3FFFFF, 0x000000 (wrap); tx 6 bytes in order.
//  4. Send 5A -> no SDRAM request; tx 0x3F; then 72 00 00 01 is serviced normally.
//  5. Send 77 00, then idle TimeoutCycles+1 clocks -> tx 0x21; no o_wr_req; back in IDLE.
//  6. Assert i_rst during burst SEND -> the next cycle all outputs are 0; a fresh 'r' command works.

Source files
------------

// File: rtl/uart_sdram_bridge_pkg.sv
// Shared types and byte constants for the UART-to-SDRAM command bridge.
package uart_sdram_bridge_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    GET_COUNT,
    ISSUE_WR,
    ISSUE_RD,
    WAIT_RD,
    SEND,
    SEND_ACK,
    SEND_ERR
  } bridge_state_t;

  localparam logic [7:0] CMD_WR      = 8'h77;
  localparam logic [7:0] CMD_RD      = 8'h72;
  localparam logic [7:0] CMD_BURST   = 8'h62;
  localparam logic [7:0] RSP_ACK     = 8'h4B;
  localparam logic [7:0] RSP_BADCMD  = 8'h3F;
  localparam logic [7:0] RSP_TIMEOUT = 8'h21;

  // Number of UART bytes needed to carry a field of the given bit width.
  function automatic int unsigned bytes_for(input int unsigned bits);
    return (bits + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/uart_sdram_cmd_bridge_if.sv
// UART byte handshakes plus sdram_ctrl request ports; master = bridge side.
interface uart_sdram_cmd_bridge_if #(
  parameter int unsigned AddrWidth = 22,
  parameter int unsigned DataWidth = 16
);
  logic [7:0]           i_rx_data;
  logic                 i_rx_rdy;
  logic                 o_rx_req;
  logic [7:0]           o_tx_data;
  logic                 o_tx_req;
  logic                 i_tx_rdy;
  logic                 o_wr_req;
  logic [AddrWidth-1:0] o_wr_addr;
  logic [DataWidth-1:0] o_wr_data;
  logic                 o_rd_req;
  logic [AddrWidth-1:0] o_rd_addr;
  logic [DataWidth-1:0] i_rd_data;
  logic                 i_rd_rdy;
  logic                 i_ctrl_rdy;

  modport master (
    input  i_rx_data, i_rx_rdy, i_tx_rdy, i_rd_data, i_rd_rdy, i_ctrl_rdy,
    output o_rx_req, o_tx_data, o_tx_req, o_wr_req, o_wr_addr, o_wr_data,
           o_rd_req, o_rd_addr
  );

  modport slave (
    output i_rx_data, i_rx_rdy, i_tx_rdy, i_rd_data, i_rd_rdy, i_ctrl_rdy,
    input  o_rx_req, o_tx_data, o_tx_req, o_wr_req, o_wr_addr, o_wr_data,
           o_rd_req, o_rd_addr
  );
endinterface

// File: rtl/bridge_timeout_ctr.sv
// Inter-byte idle counter; o_expire pulses once after TimeoutCycles enabled cycles.
module bridge_timeout_ctr #(
  parameter int unsigned TimeoutCycles = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt;

  // Saturates at TimeoutCycles so the expire pulse cannot repeat without a clear.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cnt      <= '0;
      o_expire <= 1'b0;
    end else if (i_en) begin
      o_expire <= (cnt == CntW'(TimeoutCycles - 1));
      if (cnt != CntW'(TimeoutCycles)) cnt <= cnt + CntW'(1);
    end else begin
      o_expire <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_sdram_cmd_bridge.sv
// Byte-stream command interpreter: 'w' write, 'r' read, 'b' burst read, with error and timeout replies.
module uart_sdram_cmd_bridge
  import uart_sdram_bridge_pkg::*;
#(
  parameter int unsigned AddrWidth     = 22,
  parameter int unsigned DataWidth     = 16,
  parameter int unsigned TimeoutCycles = 1_000_000,
  parameter int unsigned MaxBurst      = 256
) (
  input logic                     i_clk,
  input logic                     i_rst,
  uart_sdram_cmd_bridge_if.master bus
);
  localparam int unsigned AB     = bytes_for(AddrWidth);
  localparam int unsigned DB     = bytes_for(DataWidth);
  localparam int unsigned TxW    = DB * 8;
  localparam int unsigned CntW   = $clog2(((AB > DB) ? AB : DB) + 1);
  localparam int unsigned BurstW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;

  bridge_state_t        state;
  logic [7:0]           opcode;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] data_q;
  logic [BurstW-1:0]    burst_left;
  logic [CntW-1:0]      byte_cnt;
  logic [TxW-1:0]       tx_shift;
  logic [7:0]           err_code;
  logic                 expire;

  logic                 rx_req_q, tx_req_q, wr_req_q, rd_req_q;
  logic [7:0]           tx_data_q;
  logic [AddrWidth-1:0] wr_addr_q, rd_addr_q;
  logic [DataWidth-1:0] wr_data_q;

  logic in_get_c, rx_fire_c, tx_fire_c;

  assign in_get_c  = (state == GET_ADDR) || (state == GET_DATA) || (state == GET_COUNT);
  // Bytes are only pulled while parsing; a pending timeout wins over a late byte.
  assign rx_fire_c = ((state == IDLE) || in_get_c) && bus.i_rx_rdy && !rx_req_q && !expire;
  assign tx_fire_c = bus.i_tx_rdy && !tx_req_q;

  assign bus.o_rx_req  = rx_req_q;
  assign bus.o_tx_req  = tx_req_q;
  assign bus.o_tx_data = tx_data_q;
  assign bus.o_wr_req  = wr_req_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_wr_data = wr_data_q;
  assign bus.o_rd_req  = rd_req_q;
  assign bus.o_rd_addr = rd_addr_q;

  bridge_timeout_ctr #(.TimeoutCycles(TimeoutCycles)) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (in_get_c),
    .i_clr    (rx_fire_c || !in_get_c),
    .o_expire (expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      opcode     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      burst_left <= '0;
      byte_cnt   <= '0;
      tx_shift   <= '0;
      err_code   <= '0;
      rx_req_q   <= 1'b0;
      tx_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      tx_data_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
    end else begin
      rx_req_q <= rx_fire_c;
      tx_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      if (expire) begin
        err_code <= RSP_TIMEOUT;
        state    <= SEND_ERR;
      end else begin
        case (state)
          IDLE: if (rx_fire_c) begin
            opcode     <= bus.i_rx_data;
            byte_cnt   <= '0;
            burst_left <= '0;
            if (bus.i_rx_data == CMD_WR || bus.i_rx_data == CMD_RD || bus.i_rx_data == CMD_BURST) begin
              state <= GET_ADDR;
            end else begin
              err_code <= RSP_BADCMD;
              state    <= SEND_ERR;
            end
          end
          // MSB-first shift-in; the width cast drops excess high bits.
          GET_ADDR: if (rx_fire_c) begin
            addr_q <= AddrWidth'({addr_q, bus.i_rx_data});
            if (byte_cnt == CntW'(AB - 1)) begin
              byte_cnt <= '0;
              if (opcode == CMD_WR)         state <= GET_DATA;
              else if (opcode == CMD_BURST) state <= GET_COUNT;
              else                          state <= ISSUE_RD;
            end else begin
              byte_cnt <= byte_cnt + CntW'(1);
            end
          end
          GET_DATA: if (rx_fire_c) begin
            data_q <= DataWidth'({data_q, bus.i_rx_data});
            if (byte_cnt == CntW'(DB - 1)) begin
              byte_cnt <= '0;
              state    <= ISSUE_WR;
            end else begin
              byte_cnt <= byte_cnt + CntW'(1);
            end
          end
          GET_COUNT: if (rx_fire_c) begin
            burst_left <= (32'(bus.i_rx_data) >= MaxBurst) ? BurstW'(MaxBurst - 1)
                                                           : BurstW'(bus.i_rx_data);
            state      <= ISSUE_RD;
          end
          ISSUE_WR: if (bus.i_ctrl_rdy) begin
            wr_req_q  <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= data_q;
            state     <= SEND_ACK;
          end
          ISSUE_RD: if (bus.i_ctrl_rdy) begin
            rd_req_q  <= 1'b1;
            rd_addr_q <= addr_q;
            state     <= WAIT_RD;
          end
          WAIT_RD: if (bus.i_rd_rdy) begin
            tx_shift <= TxW'(bus.i_rd_data);
            byte_cnt <= '0;
            state    <= SEND;
          end
          SEND: if (tx_fire_c) begin
            tx_req_q  <= 1'b1;
            tx_data_q <= tx_shift[TxW-1 -: 8];
            tx_shift  <= tx_shift << 8;
            if (byte_cnt == CntW'(DB - 1)) begin
              byte_cnt <= '0;
              if (burst_left != '0) begin
                burst_left <= burst_left - BurstW'(1);
                addr_q     <= addr_q + AddrWidth'(1);
                state      <= ISSUE_RD;
              end else begin
                state <= IDLE;
              end
            end else begin
              byte_cnt <= byte_cnt + CntW'(1);
            end
          end
          SEND_ACK: if (tx_fire_c) begin
            tx_req_q  <= 1'b1;
            tx_data_q <= RSP_ACK;
            state     <= IDLE;
          end
          SEND_ERR: if (tx_fire_c) begin
            tx_req_q  <= 1'b1;
            tx_data_q <= err_code;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
